quad_decoder: RTL and testbench

- Quadrature decoder for the stepper-motor feedback path.
- Consumes the debounced encoder phases A/B and index Z produced by the input filter stage.
- Produces a signed position count, per-count step pulse, direction, index-latched position, count period for speed estimation, and a sticky illegal-transition flag.
- Runs on the 50 MHz system clock. Inputs are treated as already synchronous; no extra resynchronisation.

---
 rtl/quad_decoder.sv | 110 +++++++++++
 tb/tb_quad_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: A/B phases to signed position, step pulse, direction, index capture, count period, error flag.
// Latency: 1 clk from a sampled A/B or Z change to the registered outputs.
// Backpressure: none; the input is sampled every clock and the outputs are registered status.
module quad_decoder #(
    parameter int         POS_WIDTH = 16,
    parameter int         PER_WIDTH = 20,
    parameter logic [1:0] INIT_AB   = 2'b00,
    parameter logic       DIR_INV   = 1'b0
) (
    input  logic                 clk,
    input  logic                 xres,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_z,
    input  logic                 clr,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 cnt_pls,
    output logic                 dir,
    output logic [POS_WIDTH-1:0] pos_z,
    output logic                 z_valid,
    output logic [PER_WIDTH-1:0] period,
    output logic                 err
);

    localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);
    localparam logic [PER_WIDTH-1:0] PER_ONE  = PER_WIDTH'(1);
    localparam logic [PER_WIDTH-1:0] PER_ONES = '1;

    logic [1:0]           ab;
    logic [1:0]           ab_prev;
    logic                 z_prev;
    logic [PER_WIDTH-1:0] per_cnt;
    logic                 fwd, rev, illegal;
    logic                 inc, dec;
    logic                 per_max;
    logic                 z_rise;

    assign ab      = {enc_a, enc_b};
    assign per_max = (per_cnt == PER_ONES);
    assign z_rise  = enc_z && !z_prev;

    // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00; both-bits-changed steps are illegal.
    always_comb begin
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        case ({ab_prev, ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd     = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev     = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
            default: ;
        endcase
    end

    assign inc = DIR_INV ? rev : fwd;
    assign dec = DIR_INV ? fwd : rev;

    always_ff @(posedge clk) begin
        if (!xres) begin
            ab_prev <= INIT_AB;
            z_prev  <= 1'b0;
            pos     <= '0;
            cnt_pls <= 1'b0;
            dir     <= 1'b1;
            pos_z   <= '0;
            z_valid <= 1'b0;
            period  <= PER_ONES;
            per_cnt <= '0;
            err     <= 1'b0;
        end else begin
            ab_prev <= ab;
            z_prev  <= enc_z;
            cnt_pls <= inc || dec;
            if (inc)
                dir <= 1'b1;
            else if (dec)
                dir <= 1'b0;

            // Period is the interval between counts; a long silence reads as all-ones.
            if (inc || dec) begin
                per_cnt <= '0;
                period  <= per_max ? PER_ONES : per_cnt + PER_ONE;
            end else if (per_max) begin
                period  <= PER_ONES;
            end else begin
                per_cnt <= per_cnt + PER_ONE;
            end

            if (clr) begin
                pos     <= '0;
                pos_z   <= '0;
                z_valid <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (inc)
                    pos <= pos + POS_ONE;
                else if (dec)
                    pos <= pos - POS_ONE;
                // Capture the pre-update position even when a count lands in the same cycle.
                if (z_rise) begin
                    pos_z   <= pos;
                    z_valid <= 1'b1;
                end
                if (illegal)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a default instance plus a narrow, direction-inverted instance.
module tb_quad_decoder;

    logic        clk = 1'b0;
    logic        xres = 1'b0;
    logic        enc_a = 1'b0, enc_b = 1'b0, enc_z = 1'b0, clr = 1'b0;
    logic [15:0] pos, pos_z;
    logic        cnt_pls, dir, z_valid, err;
    logic [19:0] period;
    logic [3:0]  pos2, pos_z2;
    logic        cnt_pls2, dir2, z_valid2, err2;
    logic [7:0]  period2;
    int          tests = 0;
    int          fails = 0;

    always #10 clk = ~clk;

    quad_decoder dut (
        .clk(clk), .xres(xres), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .clr(clr),
        .pos(pos), .cnt_pls(cnt_pls), .dir(dir), .pos_z(pos_z), .z_valid(z_valid),
        .period(period), .err(err)
    );

    quad_decoder #(.POS_WIDTH(4), .PER_WIDTH(8), .DIR_INV(1'b1)) dut2 (
        .clk(clk), .xres(xres), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .clr(clr),
        .pos(pos2), .cnt_pls(cnt_pls2), .dir(dir2), .pos_z(pos_z2), .z_valid(z_valid2),
        .period(period2), .err(err2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ab(input logic [1:0] v);
        {enc_a, enc_b} = v;
    endtask

    // Each step changes A/B and holds it for two clocks.
    task automatic step(input logic [1:0] v);
        set_ab(v);
        tick(2);
    endtask

    task automatic test_reset;
        int seen = 0;
        set_ab(2'b00);
        xres = 1'b0;
        tick(2);
        xres = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (cnt_pls) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_pls: got %0d want 0", seen); end
        tests++; if (pos !== 16'h0000) begin fails++; $display("FAIL rst_pos: got %h want 0000", pos); end
        tests++; if (period !== 20'hFFFFF) begin fails++; $display("FAIL rst_period: got %h want fffff", period); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
        tests++; if (dir !== 1'b1) begin fails++; $display("FAIL rst_dir: got %b want 1", dir); end
        tests++; if (z_valid !== 1'b0 || pos_z !== 16'h0) begin fails++; $display("FAIL rst_z: got %b/%h want 0/0000", z_valid, pos_z); end
    endtask

    task automatic test_forward;
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            set_ab(seq[i]);
            tick(1);
            tests++; if (cnt_pls !== 1'b1) begin fails++; $display("FAIL fwd_pls_hi[%0d]: got %b want 1", i, cnt_pls); end
            if (i > 0) begin
                tests++; if (period !== 20'd100) begin fails++; $display("FAIL fwd_period[%0d]: got %0d want 100", i, period); end
            end
            tick(1);
            tests++; if (cnt_pls !== 1'b0) begin fails++; $display("FAIL fwd_pls_lo[%0d]: got %b want 0", i, cnt_pls); end
            tick(98);
        end
        tests++; if (pos !== 16'd4) begin fails++; $display("FAIL fwd_pos: got %h want 0004", pos); end
        tests++; if (dir !== 1'b1) begin fails++; $display("FAIL fwd_dir: got %b want 1", dir); end
        tests++; if (pos2 !== 4'hC || dir2 !== 1'b0) begin fails++; $display("FAIL inv_fwd: got %h/%b want c/0", pos2, dir2); end
        tests++; if (period2 !== 8'd100) begin fails++; $display("FAIL inv_period: got %0d want 100", period2); end
    endtask

    task automatic test_reverse;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tests++; if (pos !== 16'h0 || pos2 !== 4'h0) begin fails++; $display("FAIL rev_clr: got %h/%h want 0000/0", pos, pos2); end
        step(2'b01);
        tests++; if (pos !== 16'h0001) begin fails++; $display("FAIL rev_preload: got %h want 0001", pos); end
        step(2'b00);
        step(2'b10);
        tests++; if (pos !== 16'hFFFF) begin fails++; $display("FAIL rev_wrap: got %h want ffff", pos); end
        step(2'b11);
        tests++; if (pos !== 16'hFFFE || dir !== 1'b0) begin fails++; $display("FAIL rev_pos: got %h/%b want fffe/0", pos, dir); end
        tests++; if (pos2 !== 4'h2 || dir2 !== 1'b1) begin fails++; $display("FAIL inv_rev: got %h/%b want 2/1", pos2, dir2); end
        // Reverse steps carry the inverted 4-bit count across the sign boundary 7 -> 8.
        step(2'b01); step(2'b00); step(2'b10); step(2'b11); step(2'b01); step(2'b00);
        tests++; if (pos2 !== 4'h8) begin fails++; $display("FAIL inv_signwrap: got %h want 8", pos2); end
        tests++; if (pos !== 16'hFFF8) begin fails++; $display("FAIL rev_pos2: got %h want fff8", pos); end
        tests++; if (period !== 20'd2) begin fails++; $display("FAIL rev_period: got %0d want 2", period); end
    endtask

    task automatic test_illegal;
        set_ab(2'b11);
        tick(1);
        tests++; if (cnt_pls !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL ill_flag: got pls=%b err=%b want 0/1", cnt_pls, err); end
        tests++; if (pos !== 16'hFFF8 || dir !== 1'b0 || period !== 20'd2) begin fails++; $display("FAIL ill_hold: got %h/%b/%0d want fff8/0/2", pos, dir, period); end
        tick(5);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %b want 1", err); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tests++; if (err !== 1'b0 || pos !== 16'h0 || z_valid !== 1'b0) begin fails++; $display("FAIL ill_clr: got %b/%h/%b want 0/0000/0", err, pos, z_valid); end
        set_ab(2'b00);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_clr_same: got %b want 0", err); end
        tick(1);
    endtask

    task automatic test_index;
        step(2'b01); step(2'b11); step(2'b10); step(2'b00);
        step(2'b01); step(2'b11); step(2'b10);
        tests++; if (pos !== 16'd7) begin fails++; $display("FAIL idx_pre: got %h want 0007", pos); end
        set_ab(2'b00);
        enc_z = 1'b1;
        tick(1);
        tests++; if (pos_z !== 16'd7 || pos !== 16'd8 || z_valid !== 1'b1) begin fails++; $display("FAIL idx_cap: got %h/%h/%b want 0007/0008/1", pos_z, pos, z_valid); end
        tests++; if (pos_z2 !== 4'h9 || pos2 !== 4'h8) begin fails++; $display("FAIL inv_idx: got %h/%h want 9/8", pos_z2, pos2); end
        enc_z = 1'b0;
        tick(2);
        enc_z = 1'b1;
        tick(1);
        tests++; if (pos_z !== 16'd8) begin fails++; $display("FAIL idx_over: got %h want 0008", pos_z); end
        enc_z = 1'b0;
        tick(1);
        clr = 1'b1;
        enc_z = 1'b1;
        tick(1);
        clr = 1'b0;
        enc_z = 1'b0;
        tests++; if (pos_z !== 16'h0 || z_valid !== 1'b0 || pos !== 16'h0) begin fails++; $display("FAIL idx_clr: got %h/%b/%h want 0000/0/0000", pos_z, z_valid, pos); end
        tick(1);
    endtask

    task automatic test_stall;
        set_ab(2'b01);
        tick(50);
        set_ab(2'b11);
        tick(1);
        tests++; if (period !== 20'd50 || period2 !== 8'd50) begin fails++; $display("FAIL stall_meas: got %0d/%0d want 50/50", period, period2); end
        tick(300);
        tests++; if (period2 !== 8'hFF) begin fails++; $display("FAIL stall_sat: got %h want ff", period2); end
        tests++; if (period !== 20'd50) begin fails++; $display("FAIL stall_hold: got %0d want 50", period); end
    endtask

    task automatic test_reset_mid;
        set_ab(2'b10);
        tick(1);
        enc_z = 1'b1;
        tick(1);
        set_ab(2'b00);
        xres = 1'b0;
        tick(1);
        tests++; if (pos !== 16'h0 || cnt_pls !== 1'b0 || dir !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL mid_rst: got %h/%b/%b/%b want 0000/0/1/0", pos, cnt_pls, dir, err); end
        tests++; if (pos_z !== 16'h0 || z_valid !== 1'b0 || period !== 20'hFFFFF) begin fails++; $display("FAIL mid_rst_z: got %h/%b/%h want 0000/0/fffff", pos_z, z_valid, period); end
        // Released at 11 against the 00 history: one illegal step is the expected outcome.
        set_ab(2'b11);
        enc_z = 1'b0;
        xres = 1'b1;
        tick(1);
        tests++; if (err !== 1'b1 || pos !== 16'h0 || cnt_pls !== 1'b0) begin fails++; $display("FAIL mid_release: got %b/%h/%b want 1/0000/0", err, pos, cnt_pls); end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_reverse;
        test_illegal;
        test_index;
        test_stall;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
